// File: rtl/mem_access_unit_pkg.sv
// Shared load/store constants: memControl op/size codes, error causes,
// LSU state encodings and the alignment rule.
package mem_access_unit_pkg;

   localparam logic [1:0] MEMOP_NONE  = 2'b00;
   localparam logic [1:0] MEMOP_LOAD  = 2'b01;
   localparam logic [1:0] MEMOP_STORE = 2'b10;

   localparam logic [1:0] MEMSZ_B = 2'b00;
   localparam logic [1:0] MEMSZ_H = 2'b01;
   localparam logic [1:0] MEMSZ_W = 2'b10;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_BUS      = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_DONE = 2'b10
   } lsu_state_e;

   // Size 11 is reported as misaligned as well.
   function automatic logic is_misaligned(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      logic bad;
      bad = 1'b1;
      case (size)
         MEMSZ_B: bad = 1'b0;
         MEMSZ_H: bad = lo[0];
         MEMSZ_W: bad = |lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication and byte enables, plus load
// lane extraction with sign/zero extension.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addrLo,
   input  logic        loadUnsigned,
   input  logic [31:0] storeData,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic [7:0]  lb;
   logic [15:0] lh;

   always_comb begin
      be    = 4'b0000;
      wdata = storeData;
      ldata = rdata;
      lb    = rdata[{addrLo, 3'b000} +: 8];
      lh    = addrLo[1] ? rdata[31:16] : rdata[15:0];
      unique case (size)
         MEMSZ_B: begin
            be    = 4'b0001 << addrLo;
            wdata = {4{storeData[7:0]}};
            ldata = {{24{lb[7] & ~loadUnsigned}}, lb};
         end
         MEMSZ_H: begin
            be    = addrLo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{storeData[15:0]}};
            ldata = {{16{lh[15] & ~loadUnsigned}}, lh};
         end
         MEMSZ_W: begin
            be    = 4'b1111;
         end
         default: begin
            be    = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: runs one valid/ready data-bus transaction per memControl
// op, stalls the pipeline meanwhile and returns aligned, extended load data.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [3:0]        memControl,
   input  logic              loadUnsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       storeData,
   output logic              lsuStall,
   output logic              lsuDone,
   output logic [31:0]       loadData,
   output logic              lsuErr,
   output logic [1:0]        errCause,
   output logic              busValid,
   output logic              busWe,
   output logic [ADDR_W-1:0] busAddr,
   output logic [31:0]       busWdata,
   output logic [3:0]        busBe,
   input  logic              busReady,
   input  logic [31:0]       busRdata,
   input  logic              busErr
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        lo_q, lo_d;
   logic [ADDR_W-3:0] waddr_q, waddr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [31:0]       ldata_q, ldata_d;
   logic [1:0]        cause_q, cause_d;

   logic [1:0]  op;
   logic        idle;
   logic        start;
   logic [1:0]  al_size;
   logic [1:0]  al_lo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_ldata;

   assign op    = memControl[3:2];
   assign idle  = state_q == ST_IDLE;
   assign start = idle && (op == MEMOP_LOAD || op == MEMOP_STORE);

   // One aligner: store side in IDLE, load side from registered fields.
   assign al_size = idle ? memControl[1:0] : size_q;
   assign al_lo   = idle ? addr[1:0] : lo_q;

   mem_lane_align u_align (
      .size         (al_size),
      .addrLo       (al_lo),
      .loadUnsigned (uns_q),
      .storeData    (storeData),
      .rdata        (busRdata),
      .be           (al_be),
      .wdata        (al_wdata),
      .ldata        (al_ldata)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      lo_d    = lo_q;
      waddr_d = waddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      ldata_d = ldata_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_misaligned(memControl[1:0], addr[1:0])) begin
                  state_d = ST_DONE;
                  cause_d = ERR_MISALIGN;
                  ldata_d = 32'h0;
               end else begin
                  state_d = ST_BUS;
                  we_d    = op == MEMOP_STORE;
                  size_d  = memControl[1:0];
                  uns_d   = loadUnsigned;
                  lo_d    = addr[1:0];
                  waddr_d = addr[ADDR_W-1:2];
                  be_d    = al_be;
                  wdata_d = al_wdata;
                  cnt_d   = 8'd0;
               end
            end
         end
         ST_BUS: begin
            if (busReady) begin
               state_d = ST_DONE;
               if (busErr) begin
                  cause_d = ERR_BUS;
                  ldata_d = 32'h0;
               end else begin
                  cause_d = ERR_NONE;
                  ldata_d = we_q ? 32'h0 : al_ldata;
               end
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d = ST_DONE;
               cause_d = ERR_TIMEOUT;
               ldata_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         lo_q    <= 2'b00;
         waddr_q <= '0;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0;
         cnt_q   <= 8'd0;
         ldata_q <= 32'h0;
         cause_q <= ERR_NONE;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         lo_q    <= lo_d;
         waddr_q <= waddr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         ldata_q <= ldata_d;
         cause_q <= cause_d;
      end
   end

   assign lsuStall = start || state_q == ST_BUS;
   assign lsuDone  = state_q == ST_DONE;
   assign lsuErr   = lsuDone && cause_q != ERR_NONE;
   assign errCause = cause_q;
   assign loadData = ldata_q;
   assign busValid = state_q == ST_BUS;
   assign busWe    = busValid && we_q;
   assign busBe    = busValid ? be_q : 4'b0000;
   assign busAddr  = {waddr_q, 2'b00};
   assign busWdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mem_access_unit;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  memControl;
   logic        loadUnsigned;
   logic [31:0] addr;
   logic [31:0] storeData;
   logic        lsuStall;
   logic        lsuDone;
   logic [31:0] loadData;
   logic        lsuErr;
   logic [1:0]  errCause;
   logic        busValid;
   logic        busWe;
   logic [31:0] busAddr;
   logic [31:0] busWdata;
   logic [3:0]  busBe;
   logic        busReady;
   logic [31:0] busRdata;
   logic        busErr;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .memControl   (memControl),
      .loadUnsigned (loadUnsigned),
      .addr         (addr),
      .storeData    (storeData),
      .lsuStall     (lsuStall),
      .lsuDone      (lsuDone),
      .loadData     (loadData),
      .lsuErr       (lsuErr),
      .errCause     (errCause),
      .busValid     (busValid),
      .busWe        (busWe),
      .busAddr      (busAddr),
      .busWdata     (busWdata),
      .busBe        (busBe),
      .busReady     (busReady),
      .busRdata     (busRdata),
      .busErr       (busErr)
   );

   int chk_cnt = 0;
   int pass_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic bit f_bad(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
   endfunction

   function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 4'(1 << (a % 4));
      if (sz == 2'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] sd);
      if (sz == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] f_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] s;
      logic [31:0] v;
      s = rd >> (8 * (a % 4));
      if (sz == 2'd0) begin
         v = s & 32'hFF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = s & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   logic        m_bus, m_done, m_we, m_uns;
   int          m_wait;
   logic [31:0] m_addr, m_sd, m_ld;
   logic [1:0]  m_size, m_cause;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_bus = 0; m_done = 0; m_we = 0; m_uns = 0; m_wait = 0;
         m_addr = 0; m_sd = 0; m_ld = 0; m_size = 0; m_cause = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_bus) begin
         if (busReady) begin
            m_bus = 0; m_done = 1;
            m_cause = busErr ? 2'd2 : 2'd0;
            m_ld = (busErr || m_we) ? 32'h0 : f_load(m_size, m_uns, m_addr, busRdata);
         end else if (m_wait == TIMEOUT) begin
            m_bus = 0; m_done = 1; m_cause = 2'd3; m_ld = 32'h0;
         end else begin
            m_wait++;
         end
      end else if (memControl[3:2] == 2'd1 || memControl[3:2] == 2'd2) begin
         if (f_bad(memControl[1:0], addr)) begin
            m_done = 1; m_cause = 2'd1; m_ld = 32'h0;
         end else begin
            m_bus = 1; m_wait = 1;
            m_addr = addr; m_sd = storeData; m_size = memControl[1:0];
            m_uns = loadUnsigned; m_we = memControl[3:2] == 2'd2;
         end
      end
   end

   always @(negedge clk) begin : compare
      logic st;
      st = m_bus || (!m_done && (memControl[3:2] == 2'd1 || memControl[3:2] == 2'd2));
      chk("cyc_busValid", busValid, m_bus);
      chk("cyc_lsuStall", lsuStall, st);
      chk("cyc_lsuDone", lsuDone, m_done);
      chk("cyc_lsuErr", lsuErr, m_done && m_cause != 0);
      chk("cyc_errCause", errCause, m_cause);
      chk("cyc_loadData", loadData, m_ld);
      if (m_bus) begin
         chk("cyc_busWe", busWe, m_we);
         chk("cyc_busAddr", busAddr, m_addr & ~32'h3);
         chk("cyc_busBe", busBe, f_be(m_size, m_addr));
         chk("cyc_busWdata", busWdata, f_wdata(m_size, m_sd));
      end
   end

   // ---------------- driver ----------------
   int          r_lat, r_vc;
   bit          r_stable;
   logic [31:0] r_addr, r_wd, r_ld;
   logic [3:0]  r_be;
   logic        r_we, r_err;
   logic [1:0]  r_cause;

   task automatic do_op(input logic [3:0] mc, input logic uns, input logic [31:0] a,
                        input logic [31:0] sd, input int rdy_at, input logic berr,
                        input logic [31:0] rd);
      int cyc;
      @(posedge clk); #1;
      memControl = mc; loadUnsigned = uns; addr = a; storeData = sd;
      @(posedge clk); #1;
      memControl = 4'b0000;
      cyc = 1; r_vc = 0; r_stable = 1;
      r_addr = 0; r_wd = 0; r_be = 0; r_we = 0;
      while (!lsuDone && cyc < 60) begin
         if (busValid) begin
            if (r_vc == 0) begin
               r_addr = busAddr; r_be = busBe; r_wd = busWdata; r_we = busWe;
            end else if (busAddr !== r_addr || busBe !== r_be ||
                         busWdata !== r_wd || busWe !== r_we) begin
               r_stable = 0;
            end
            if (r_vc == rdy_at) begin
               busReady = 1'b1; busErr = berr; busRdata = rd;
            end
            r_vc++;
         end
         @(posedge clk); #1;
         busReady = 1'b0; busErr = 1'b0; busRdata = 32'h0;
         cyc++;
      end
      chk("done_seen", lsuDone, 1'b1);
      r_lat = cyc;
      r_ld = loadData; r_err = lsuErr; r_cause = errCause;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      memControl = 0; loadUnsigned = 0; addr = 0; storeData = 0;
      busReady = 0; busRdata = 0; busErr = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busValid", busValid, 1'b0);
      chk("rst_lsuStall", lsuStall, 1'b0);
      chk("rst_lsuDone", lsuDone, 1'b0);
      chk("rst_loadData", loadData, 32'h0);
      chk("rst_errCause", errCause, 2'b00);
      chk("rst_busBe", busBe, 4'b0000);
      #2 rstn = 1'b1;

      // SW, minimum latency
      do_op(4'b1010, 0, 32'h104, 32'hDEADBEEF, 0, 0, 0);
      chk("sw_addr", r_addr, 32'h104);
      chk("sw_be", r_be, 4'b1111);
      chk("sw_wdata", r_wd, 32'hDEADBEEF);
      chk("sw_we", r_we, 1'b1);
      chk("sw_lat", r_lat, 2);
      chk("sw_err", r_err, 1'b0);
      chk("sw_ld", r_ld, 32'h0);

      // LB / LBU
      do_op(4'b0100, 0, 32'h203, 0, 0, 0, 32'h80AA_5511);
      chk("lb_be", r_be, 4'b1000);
      chk("lb_addr", r_addr, 32'h200);
      chk("lb_we", r_we, 1'b0);
      chk("lb_ld", r_ld, 32'hFFFFFF80);
      do_op(4'b0100, 1, 32'h203, 0, 0, 0, 32'h80AA_5511);
      chk("lbu_ld", r_ld, 32'h00000080);

      // SH / LHU / LH signed
      do_op(4'b1001, 0, 32'h012, 32'h0000_1234, 0, 0, 0);
      chk("sh_addr", r_addr, 32'h010);
      chk("sh_be", r_be, 4'b1100);
      chk("sh_wdata", r_wd, 32'h12341234);
      do_op(4'b0101, 1, 32'h010, 0, 0, 0, 32'h0000_F00D);
      chk("lhu_be", r_be, 4'b0011);
      chk("lhu_ld", r_ld, 32'h0000F00D);
      do_op(4'b0101, 0, 32'h002, 0, 0, 0, 32'h8001_0000);
      chk("lh_ld", r_ld, 32'hFFFF8001);

      // SB lane replication
      do_op(4'b1000, 0, 32'h001, 32'h1234_56AB, 0, 0, 0);
      chk("sb_be", r_be, 4'b0010);
      chk("sb_wdata", r_wd, 32'hABABABAB);

      // misaligned word and illegal size
      do_op(4'b0110, 0, 32'h102, 0, 0, 0, 0);
      chk("mis_vc", r_vc, 0);
      chk("mis_lat", r_lat, 1);
      chk("mis_err", r_err, 1'b1);
      chk("mis_cause", r_cause, 2'b01);
      chk("mis_ld", r_ld, 32'h0);
      do_op(4'b0111, 0, 32'h100, 0, 0, 0, 0);
      chk("ill_cause", r_cause, 2'b01);
      chk("ill_vc", r_vc, 0);

      // delayed ready with bus error
      do_op(4'b0110, 0, 32'h040, 0, 3, 1, 32'h5555_AAAA);
      chk("berr_vc", r_vc, 4);
      chk("berr_stable", r_stable, 1'b1);
      chk("berr_err", r_err, 1'b1);
      chk("berr_cause", r_cause, 2'b10);
      chk("berr_ld", r_ld, 32'h0);

      // no ready: timeout abort
      do_op(4'b1010, 0, 32'h044, 32'h0BAD_F00D, -1, 0, 0);
      chk("to_vc", r_vc, TIMEOUT);
      chk("to_stable", r_stable, 1'b1);
      chk("to_err", r_err, 1'b1);
      chk("to_cause", r_cause, 2'b11);
      @(posedge clk); #1;
      chk("to_hold_cause", errCause, 2'b11);
      chk("to_after_err", lsuErr, 1'b0);

      // op 11 ignored
      memControl = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("op11_stall", lsuStall, 1'b0);
         chk("op11_busValid", busValid, 1'b0);
         chk("op11_done", lsuDone, 1'b0);
      end
      memControl = 4'b0000;

      // reset in the middle of BUS
      @(posedge clk); #1;
      memControl = 4'b0110; addr = 32'h20;
      @(posedge clk); #1;
      memControl = 4'b0000;
      chk("rstmid_pre_valid", busValid, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk("rstmid_valid", busValid, 1'b0);
      chk("rstmid_stall", lsuStall, 1'b0);
      chk("rstmid_done", lsuDone, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rstmid_done2", lsuDone, 1'b0);
      chk("rstmid_cause", errCause, 2'b00);
      #2 rstn = 1'b1;
      do_op(4'b0110, 0, 32'h0, 0, 0, 0, 32'h1234_5678);
      chk("post_ld", r_ld, 32'h12345678);
      chk("post_err", r_err, 1'b0);
      chk("post_lat", r_lat, 2);
      chk("post_addr", r_addr, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
